// File: rtl/raster_pkg.sv
// Shared types and accelerator register map for the AHB raster master.
package raster_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransNonseq = 2'b10
  } htrans_t;

  typedef enum logic [3:0] {
    StIdle,
    StVtx,
    StPxX,
    StPxY,
    StSettle,
    StRd,
    StFbWr,
    StNext,
    StDone
  } state_t;

  // Byte offsets from the accelerator base; vertices occupy +0..+20.
  localparam logic [31:0] HwaOffX      = 32'd24;
  localparam logic [31:0] HwaOffY      = 32'd28;
  localparam logic [31:0] HwaOffResult = 32'd32;

endpackage

// File: rtl/ahb_master_port.sv
// Single-outstanding AHB-Lite transfer engine: one request in, one ack pulse out.
module ahb_master_port
  import raster_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        write,
  output logic        ack,
  output logic [31:0] rdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY
);

  typedef enum logic [1:0] {PhIdle, PhAddr, PhData} phase_t;

  phase_t      phase_q, phase_d;
  logic [31:0] haddr_q, haddr_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        hwrite_q, hwrite_d;

  always_comb begin
    phase_d  = phase_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    hwrite_d = hwrite_q;
    ack      = 1'b0;
    unique case (phase_q)
      PhIdle: begin
        if (req) begin
          phase_d  = PhAddr;
          haddr_d  = addr;
          hwrite_d = write;
          hwdata_d = write ? wdata : '0;
        end
      end
      PhAddr: if (HREADY) phase_d = PhData;
      PhData: begin
        if (HREADY) begin
          phase_d = PhIdle;
          ack     = 1'b1;
        end
      end
      default: phase_d = PhIdle;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      phase_q  <= PhIdle;
      haddr_q  <= '0;
      hwdata_q <= '0;
      hwrite_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      hwrite_q <= hwrite_d;
    end
  end

  // Only the address phase is NONSEQ, so address and data phases never overlap.
  assign HTRANS = (phase_q == PhAddr) ? HtransNonseq : HtransIdle;
  assign HADDR  = haddr_q;
  assign HWRITE = hwrite_q;
  assign HWDATA = hwdata_q;
  assign rdata  = HRDATA;

endmodule

// File: rtl/ahb_raster_master.sv
// Scan FSM: loads triangle vertices into the accelerator, then tests and paints each box pixel.
module ahb_raster_master
  import raster_pkg::*;
#(
  parameter logic [31:0] HWA_BASE  = 32'h5000_0000,
  parameter logic [31:0] FB_BASE   = 32'h2000_0000,
  parameter int unsigned LOG2_FB_W = 7,
  parameter int unsigned COORD_W   = 16,
  parameter int unsigned SETTLE    = 3
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 start,
  input  logic [6*COORD_W-1:0] vtx,
  input  logic [COORD_W-1:0]   x_min,
  input  logic [COORD_W-1:0]   x_max,
  input  logic [COORD_W-1:0]   y_min,
  input  logic [COORD_W-1:0]   y_max,
  input  logic [31:0]          colour,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          pix_count,
  output logic [31:0]          HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [31:0]          HWDATA,
  input  logic [31:0]          HRDATA,
  input  logic                 HREADY
);

  localparam int unsigned     CntW   = COORD_W + 1;
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  state_t               state_q, state_d;
  logic [2:0]           vcnt_q, vcnt_d;
  logic [7:0]           settle_q, settle_d;
  logic [CntW-1:0]      x_q, x_d, y_q, y_d;
  logic [31:0]          pix_q, pix_d;
  logic [6*COORD_W-1:0] vtx_q;
  logic [COORD_W-1:0]   xmin_q, xmax_q, ymin_q, ymax_q;
  logic [31:0]          colour_q;

  logic        req, ack, write;
  logic [31:0] addr, wdata, rdata, fb_idx;
  logic [CntW-1:0]    x_inc, y_inc;
  logic [COORD_W-1:0] vtx_sel;
  logic        box_empty;
  logic        unused_rdata;

  function automatic logic [31:0] sext(input logic [COORD_W-1:0] c);
    return 32'($signed(c));
  endfunction

  assign vtx_sel   = vtx_q[32'(vcnt_q) * COORD_W +: COORD_W];
  assign x_inc     = x_q + CntOne;
  assign y_inc     = y_q + CntOne;
  assign box_empty = (xmin_q > xmax_q) || (ymin_q > ymax_q);
  assign fb_idx    = (32'(y_q[COORD_W-1:0]) << LOG2_FB_W) + 32'(x_q[COORD_W-1:0]);
  assign unused_rdata = ^rdata[31:1];

  always_comb begin
    state_d  = state_q;
    vcnt_d   = vcnt_q;
    settle_d = settle_q;
    x_d      = x_q;
    y_d      = y_q;
    pix_d    = pix_q;
    req      = 1'b0;
    write    = 1'b1;
    addr     = '0;
    wdata    = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StVtx;
          vcnt_d  = '0;
          pix_d   = '0;
        end
      end
      StVtx: begin
        req   = 1'b1;
        addr  = HWA_BASE + {27'd0, vcnt_q, 2'b00};
        wdata = sext(vtx_sel);
        if (ack) begin
          vcnt_d = vcnt_q + 3'd1;
          if (vcnt_q == 3'd5) begin
            x_d     = {1'b0, xmin_q};
            y_d     = {1'b0, ymin_q};
            state_d = box_empty ? StDone : StPxX;
          end
        end
      end
      StPxX: begin
        req   = 1'b1;
        addr  = HWA_BASE + HwaOffX;
        wdata = sext(x_q[COORD_W-1:0]);
        if (ack) state_d = StPxY;
      end
      StPxY: begin
        req   = 1'b1;
        addr  = HWA_BASE + HwaOffY;
        wdata = sext(y_q[COORD_W-1:0]);
        if (ack) begin
          settle_d = '0;
          state_d  = (SETTLE == 0) ? StRd : StSettle;
        end
      end
      StSettle: begin
        settle_d = settle_q + 8'd1;
        if (settle_q == 8'(SETTLE - 1)) state_d = StRd;
      end
      StRd: begin
        req   = 1'b1;
        write = 1'b0;
        addr  = HWA_BASE + HwaOffResult;
        if (ack) state_d = rdata[0] ? StFbWr : StNext;
      end
      StFbWr: begin
        req   = 1'b1;
        addr  = FB_BASE + (fb_idx << 2);
        wdata = colour_q;
        if (ack) begin
          pix_d   = pix_q + 32'd1;
          state_d = StNext;
        end
      end
      StNext: begin
        // Counters are one bit wider than coordinates so x_max at full range still terminates.
        if (x_inc > {1'b0, xmax_q}) begin
          x_d     = {1'b0, xmin_q};
          y_d     = y_inc;
          state_d = (y_inc > {1'b0, ymax_q}) ? StDone : StPxX;
        end else begin
          x_d     = x_inc;
          state_d = StPxX;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= StIdle;
      vcnt_q   <= '0;
      settle_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      pix_q    <= '0;
      vtx_q    <= '0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymin_q   <= '0;
      ymax_q   <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      vcnt_q   <= vcnt_d;
      settle_q <= settle_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pix_q    <= pix_d;
      if (state_q == StIdle && start) begin
        vtx_q    <= vtx;
        xmin_q   <= x_min;
        xmax_q   <= x_max;
        ymin_q   <= y_min;
        ymax_q   <= y_max;
        colour_q <= colour;
      end
    end
  end

  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = (state_q == StDone);
  assign pix_count = pix_q;
  assign HSIZE     = 3'b010;

  ahb_master_port u_port (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .req    (req),
    .addr   (addr),
    .wdata  (wdata),
    .write  (write),
    .ack    (ack),
    .rdata  (rdata),
    .HADDR  (HADDR),
    .HTRANS (HTRANS),
    .HWRITE (HWRITE),
    .HWDATA (HWDATA),
    .HRDATA (HRDATA),
    .HREADY (HREADY)
  );

endmodule

// File: tb/tb_ahb_raster_master.sv
// Directed bench for ahb_raster_master with accelerator/framebuffer models and a transfer scoreboard.
module tb_ahb_raster_master;

  localparam logic [31:0] HWA    = 32'h5000_0000;
  localparam logic [31:0] FB     = 32'h2000_0000;
  localparam int          LOG2W  = 7;
  localparam int          CW     = 16;
  localparam int          SETTLE = 3;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
  } xfer_t;

  logic           HCLK = 1'b0;
  logic           HRESET = 1'b1;
  logic           start = 1'b0;
  logic [6*CW-1:0] vtx = '0;
  logic [CW-1:0]  x_min = '0, x_max = '0, y_min = '0, y_max = '0;
  logic [31:0]    colour = '0;
  logic           busy, done, HWRITE;
  logic [31:0]    pix_count, HADDR, HWDATA;
  logic [1:0]     HTRANS;
  logic [2:0]     HSIZE;
  logic [31:0]    HRDATA = '0;
  logic           HREADY = 1'b1;

  int    checks = 0;
  int    failures = 0;
  xfer_t sb[$];

  int          cycle = 0, done_cnt = 0, last_ack_cycle = 0, done_cycle = 0, idle_n = 0;
  bit          stall_en = 1'b0;
  int          stall_left = 0;
  logic        dp_valid = 1'b0, dp_write = 1'b0;
  logic [31:0] dp_addr = '0;
  logic        ctrl_chk = 1'b0, wd_chk = 1'b0, track = 1'b0;
  logic [34:0] ctrl_saved = '0;
  logic [31:0] wd_saved = '0;
  logic [31:0] hwa_reg [8] = '{default: '0};
  logic [31:0] fb_mem [1024] = '{default: '0};

  ahb_raster_master dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .start     (start),
    .vtx       (vtx),
    .x_min     (x_min),
    .x_max     (x_max),
    .y_min     (y_min),
    .y_max     (y_max),
    .colour    (colour),
    .busy      (busy),
    .done      (done),
    .pix_count (pix_count),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge-function test, inclusive of edges, either winding.
  function automatic bit tri_inside(input int x1, input int y1, input int x2, input int y2,
                                    input int x3, input int y3, input int px, input int py);
    int e1, e2, e3;
    e1 = (x2 - x1) * (py - y1) - (y2 - y1) * (px - x1);
    e2 = (x3 - x2) * (py - y2) - (y3 - y2) * (px - x2);
    e3 = (x1 - x3) * (py - y3) - (y1 - y3) * (px - x3);
    return (e1 >= 0 && e2 >= 0 && e3 >= 0) || (e1 <= 0 && e2 <= 0 && e3 <= 0);
  endfunction

  // Slave side: HREADY stalls and result read data, driven away from the clock edge.
  initial forever begin
    @(negedge HCLK);
    if (stall_left > 0) stall_left--;
    else if (stall_en && $urandom_range(0, 3) == 0) stall_left = $urandom_range(1, 3);
    HREADY = (stall_left == 0);
    HRDATA = $urandom();
    if (dp_valid && !dp_write && dp_addr == HWA + 32'd32)
      HRDATA[0] = tri_inside($signed(hwa_reg[0]), $signed(hwa_reg[1]), $signed(hwa_reg[2]),
                             $signed(hwa_reg[3]), $signed(hwa_reg[4]), $signed(hwa_reg[5]),
                             $signed(hwa_reg[6]), $signed(hwa_reg[7]));
  end

  // Bus monitor: protocol checks, scoreboard pops and memory models.
  always @(posedge HCLK) begin
    cycle <= cycle + 1;
    if (HRESET) begin
      dp_valid <= 1'b0;
      ctrl_chk <= 1'b0;
      wd_chk   <= 1'b0;
      track    <= 1'b0;
    end else begin
      if (done) begin
        done_cnt   <= done_cnt + 1;
        done_cycle <= cycle;
      end
      if (ctrl_chk) check("addr_hold", 96'({HADDR, HTRANS, HWRITE}), 96'(ctrl_saved));
      if (wd_chk) check("wdata_hold", 96'(HWDATA), 96'(wd_saved));
      ctrl_chk   <= (HTRANS == 2'b10) && !HREADY;
      ctrl_saved <= {HADDR, HTRANS, HWRITE};
      wd_chk     <= dp_valid && dp_write && !HREADY;
      wd_saved   <= HWDATA;
      if (dp_valid) check("htrans_in_data", 96'(HTRANS), 96'(2'b00));
      if (track) begin
        if (HTRANS == 2'b10) begin
          check("settle_gap", 96'(idle_n >= SETTLE), 96'(1));
          track <= 1'b0;
        end else begin
          idle_n <= idle_n + 1;
        end
      end
      if (dp_valid && HREADY) begin
        if (sb.size() == 0)
          check("xfer_unexpected", 96'({dp_addr, dp_write, HWDATA}), 96'(0));
        else
          check("xfer", 96'({dp_addr, dp_write, dp_write ? HWDATA : 32'h0}), 96'(sb.pop_front()));
        if (dp_write && dp_addr >= HWA && dp_addr < HWA + 32'd32)
          hwa_reg[3'((dp_addr - HWA) >> 2)] <= HWDATA;
        if (dp_write && dp_addr >= FB && dp_addr < FB + 32'd4096)
          fb_mem[10'((dp_addr - FB) >> 2)] <= HWDATA;
        if (dp_write && dp_addr == HWA + 32'd28) begin
          track  <= 1'b1;
          idle_n <= 0;
        end
        last_ack_cycle <= cycle;
        dp_valid       <= 1'b0;
      end
      if (HTRANS == 2'b10 && HREADY) begin
        check("hsize", 96'(HSIZE), 96'(3'b010));
        dp_valid <= 1'b1;
        dp_addr  <= HADDR;
        dp_write <= HWRITE;
      end
    end
  end

  task automatic run_scan(input string tag, input int x1, input int y1, input int x2,
                          input int y2, input int x3, input int y3, input int bx0, input int bx1,
                          input int by0, input int by1, input logic [31:0] col,
                          input bit stall, input bit dup_start, input bit abort);
    int c[6];
    int exp_pix, base_done, n;
    c = '{x1, y1, x2, y2, x3, y3};
    exp_pix = 0;
    @(negedge HCLK);
    vtx    = {CW'(y3), CW'(x3), CW'(y2), CW'(x2), CW'(y1), CW'(x1)};
    x_min  = CW'(bx0);
    x_max  = CW'(bx1);
    y_min  = CW'(by0);
    y_max  = CW'(by1);
    colour = col;
    stall_en = stall;
    for (int i = 0; i < 6; i++) sb.push_back('{HWA + 32'(4 * i), 1'b1, 32'(c[i])});
    for (int y = by0; y <= by1; y++) begin
      for (int x = bx0; x <= bx1; x++) begin
        sb.push_back('{HWA + 32'd24, 1'b1, 32'(x)});
        sb.push_back('{HWA + 32'd28, 1'b1, 32'(y)});
        sb.push_back('{HWA + 32'd32, 1'b0, 32'd0});
        if (tri_inside(x1, y1, x2, y2, x3, y3, x, y)) begin
          sb.push_back('{FB + 32'(((y << LOG2W) + x) << 2), 1'b1, col});
          exp_pix++;
        end
      end
    end
    base_done = done_cnt;
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    check({tag, "_busy"}, 96'(busy), 96'(1));
    if (dup_start) begin
      repeat (10) @(negedge HCLK);
      colour = ~col;
      x_max  = CW'(bx1 + 1);
      start  = 1'b1;
      @(negedge HCLK);
      start  = 1'b0;
    end
    n = 0;
    if (abort) begin
      while (!(HTRANS == 2'b10 && HADDR >= FB && HADDR < HWA) && n < 3000) begin
        @(negedge HCLK);
        n++;
      end
      check({tag, "_reach_fbwr"}, 96'(n < 3000), 96'(1));
      HRESET = 1'b1;
      @(negedge HCLK);
      check({tag, "_rst_state"}, 96'({HTRANS, busy, done}), 96'(0));
      HRESET = 1'b0;
      sb.delete();
      repeat (5) @(negedge HCLK);
      check({tag, "_no_done"}, 96'(done_cnt - base_done), 96'(0));
    end else begin
      while (done_cnt == base_done && n < 5000) begin
        @(negedge HCLK);
        n++;
      end
      check({tag, "_done_seen"}, 96'(n < 5000), 96'(1));
      repeat (3) @(negedge HCLK);
      check({tag, "_done_once"}, 96'(done_cnt - base_done), 96'(1));
      check({tag, "_pix_count"}, 96'(pix_count), 96'(exp_pix));
      check({tag, "_sb_empty"}, 96'(sb.size()), 96'(0));
      check({tag, "_idle"}, 96'(busy), 96'(0));
    end
    stall_en = 1'b0;
    repeat (4) @(negedge HCLK);
  endtask

  task automatic check_fb(input string tag, input logic [31:0] col);
    for (int x = 0; x < 10; x++)
      check({tag, "_fb"}, 96'(fb_mem[x]), 96'((x <= 8) ? col : 32'd0));
  endtask

  initial begin
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    check("reset_bus", 96'({HADDR, HTRANS, HWRITE, HWDATA}), 96'(0));
    check("reset_ctl", 96'({busy, done, pix_count}), 96'(0));
    check("reset_hsize", 96'(HSIZE), 96'(3'b010));

    run_scan("t1_basic", 0, 0, 8, 0, 0, 8, 0, 9, 0, 0, 32'hCAFE_0001, 1'b0, 1'b0, 1'b0);
    check_fb("t1", 32'hCAFE_0001);

    run_scan("t2_stall", 0, 0, 8, 0, 0, 8, 0, 9, 0, 0, 32'hCAFE_0001, 1'b1, 1'b0, 1'b0);
    check_fb("t2", 32'hCAFE_0001);

    run_scan("t3_empty", 0, 0, 8, 0, 0, 8, 5, 4, 0, 0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    check("t3_done_latency", 96'(done_cycle - last_ack_cycle), 96'(1));

    run_scan("t4_neg", -2, -2, 6, 0, 0, 5, 1, 4, 1, 3, 32'h0000_00A5, 1'b1, 1'b0, 1'b0);

    run_scan("t5_abort", 0, 0, 8, 0, 0, 8, 0, 9, 0, 0, 32'h7777_0000, 1'b0, 1'b0, 1'b1);

    run_scan("t6_dup", 0, 0, 8, 0, 0, 8, 0, 9, 0, 0, 32'h5A5A_0006, 1'b0, 1'b1, 1'b0);
    check_fb("t6", 32'h5A5A_0006);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
